// File: rtl/blas_pkg.sv
// Shared types and width helpers for the BLAS-layer streaming blocks.
package blas_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ROWS    = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Full-precision dot-product width: N products of 2*DW bits each.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int res_width(input int n, input int dw, input int sw);
        return acc_width(n, dw) + sw + 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/gemv_mac_row.sv
// Two-stage row MAC: S1 registers the lane products, S2 registers
// alpha*sum(P) + beta*C[idx] at full precision, with valid and row index alongside.
module gemv_mac_row
    import blas_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int DW   = 32,
    parameter  int SW   = 2,
    localparam int ACCW = acc_width(N, DW),
    localparam int RW   = res_width(N, DW, SW),
    localparam int IW   = $clog2(N),
    localparam int PW   = 2 * DW
) (
    input  logic            ref_clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [IW-1:0]   in_idx,
    input  logic [N*DW-1:0] a_row,
    input  logic [N*DW-1:0] b_vec,
    input  logic [N*DW-1:0] c_vec,
    input  logic [SW-1:0]   alpha,
    input  logic [SW-1:0]   beta,
    output logic            res_valid,
    output logic [IW-1:0]   res_idx,
    output logic [RW-1:0]   res
);

    logic [PW-1:0]   prod_d [N];
    logic [PW-1:0]   prod_q [N];
    logic [DW-1:0]   c_lane [N];
    logic            s1_valid;
    logic [IW-1:0]   s1_idx;
    logic [ACCW-1:0] acc;
    logic [RW-1:0]   res_d;

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign prod_d[j] = PW'(a_row[lane_lsb(j, DW) +: DW]) * PW'(b_vec[lane_lsb(j, DW) +: DW]);
        assign c_lane[j] = c_vec[lane_lsb(j, DW) +: DW];
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            for (int j = 0; j < N; j++) prod_q[j] <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_idx <= in_idx;
                for (int j = 0; j < N; j++) prod_q[j] <= prod_d[j];
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int j = 0; j < N; j++) acc = acc + ACCW'(prod_q[j]);
        res_d = RW'(alpha) * RW'(acc) + RW'(beta) * RW'(c_lane[s1_idx]);
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_idx   <= '0;
            res       <= '0;
        end else begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_idx <= s1_idx;
                res     <= res_d;
            end
        end
    end

endmodule

// File: rtl/gemv_stream.sv
// Streaming GEMV: out = alpha*A*B + beta*C, one A row per beat, result vector held until taken.
// Build option GEMV_SAT_EN: saturate each lane to all-ones instead of wrapping modulo 2^DW.
//
//   state   | meaning
//   COLLECT | waiting for B and C (either order, same edge allowed)
//   ROWS    | accepting N rows of A; alpha/beta latched on entry
//   DONE    | result presented on out_data until out_ready
module gemv_stream
    import blas_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int DW = 32,
    parameter  int SW = 2,
    localparam int RW = res_width(N, DW, SW),
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic            ref_clk,
    input  logic            rst_n,
    input  logic [SW-1:0]   alpha,
    input  logic [SW-1:0]   beta,
    input  logic [N*DW-1:0] a_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [N*DW-1:0] b_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [N*DW-1:0] c_data,
    input  logic            c_valid,
    output logic            c_ready,
    output logic [N*DW-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [CW-1:0] ROWS_MAX = CW'(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
`ifdef GEMV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    state_t          state, state_n;
    logic            b_have, c_have, b_have_n, c_have_n;
    logic [CW-1:0]   row_cnt, row_cnt_n;
    logic            latch_scale;
    logic            a_ready_n, b_ready_n, c_ready_n;
    logic [N*DW-1:0] b_q, c_q;
    logic [SW-1:0]   alpha_q, beta_q;
    logic [DW-1:0]   res_buf [N];
    logic            a_fire, b_fire, c_fire;
    logic            mac_valid;
    logic [IW-1:0]   mac_idx;
    logic [RW-1:0]   mac_res;
    logic            mac_ovf;
    logic [DW-1:0]   lane_out;

    assign a_fire    = a_valid & a_ready;
    assign b_fire    = b_valid & b_ready;
    assign c_fire    = c_valid & c_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        state_n     = state;
        b_have_n    = b_have | b_fire;
        c_have_n    = c_have | c_fire;
        row_cnt_n   = row_cnt + CW'(a_fire);
        latch_scale = 1'b0;
        case (state)
            COLLECT: begin
                if (b_have && c_have) begin
                    state_n     = ROWS;
                    latch_scale = 1'b1;
                end
            end
            ROWS: begin
                if (mac_valid && mac_idx == LAST_IDX) state_n = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_n   = COLLECT;
                    b_have_n  = 1'b0;
                    c_have_n  = 1'b0;
                    row_cnt_n = '0;
                end
            end
            default: state_n = COLLECT;
        endcase
        // Ready flags are registered, so they are derived from next-cycle state.
        a_ready_n = (state_n == ROWS) && (row_cnt_n < ROWS_MAX);
        b_ready_n = (state_n == COLLECT) && !b_have_n;
        c_ready_n = (state_n == COLLECT) && !c_have_n;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            b_have  <= 1'b0;
            c_have  <= 1'b0;
            row_cnt <= '0;
            a_ready <= 1'b0;
            b_ready <= 1'b0;
            c_ready <= 1'b0;
            b_q     <= '0;
            c_q     <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
        end else begin
            state   <= state_n;
            b_have  <= b_have_n;
            c_have  <= c_have_n;
            row_cnt <= row_cnt_n;
            a_ready <= a_ready_n;
            b_ready <= b_ready_n;
            c_ready <= c_ready_n;
            if (b_fire) b_q <= b_data;
            if (c_fire) c_q <= c_data;
            if (latch_scale) begin
                alpha_q <= alpha;
                beta_q  <= beta;
            end
        end
    end

    gemv_mac_row #(.N(N), .DW(DW), .SW(SW)) u_mac (
        .ref_clk  (ref_clk),
        .rst_n    (rst_n),
        .in_valid (a_fire),
        .in_idx   (row_cnt[IW-1:0]),
        .a_row    (a_data),
        .b_vec    (b_q),
        .c_vec    (c_q),
        .alpha    (alpha_q),
        .beta     (beta_q),
        .res_valid(mac_valid),
        .res_idx  (mac_idx),
        .res      (mac_res)
    );

    assign mac_ovf  = |mac_res[RW-1:DW];
    assign lane_out = (SAT && mac_ovf) ? {DW{1'b1}} : mac_res[DW-1:0];

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) res_buf[i] <= '0;
        end else if (mac_valid) begin
            res_buf[mac_idx] <= lane_out;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) out_data[lane_lsb(i, DW) +: DW] = res_buf[i];
    end

endmodule

// File: tb/tb_gemv_stream.sv
// Directed bench for gemv_stream with a queue of expected result vectors from an arithmetic model.
module tb_gemv_stream;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int W  = N * DW;

    logic          ref_clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] alpha, beta;
    logic [W-1:0]  a_data, b_data, c_data, out_data;
    logic          a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
    logic          out_valid, out_ready;

    gemv_stream #(.N(N), .DW(DW), .SW(SW)) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .alpha(alpha), .beta(beta),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 ref_clk = ~ref_clk;

    int cyc = 0;
    always @(posedge ref_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input int unsigned x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    // out[i] = alpha * sum_j A[i][j]*B[j] + beta*C[i], then wrap or saturate.
    function automatic logic [W-1:0] model(input logic [W-1:0] a[N], input logic [W-1:0] b,
                                           input logic [W-1:0] c, input int unsigned al,
                                           input int unsigned be);
        logic [W-1:0] o;
        logic [127:0] sum, r;
        o = '0;
        for (int i = 0; i < N; i++) begin
            sum = '0;
            for (int j = 0; j < N; j++)
                sum = sum + 128'(a[i][j*DW +: DW]) * 128'(b[j*DW +: DW]);
            r = 128'(al) * sum + 128'(be) * 128'(c[i*DW +: DW]);
`ifdef GEMV_SAT_EN
            o[i*DW +: DW] = ((r >> DW) != 0) ? {DW{1'b1}} : r[DW-1:0];
`else
            o[i*DW +: DW] = r[DW-1:0];
`endif
        end
        return o;
    endfunction

    // Every cycle a result is presented it must equal the oldest outstanding expectation.
    always @(negedge ref_clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", W'(out_valid), W'(0));
            end else begin
                check("out_data_model", out_data, exp_q[0]);
                check("bc_ready_in_done", W'({b_ready, c_ready}), W'(0));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_a(input logic [W-1:0] d, output int acc_cyc);
        a_data  = d;
        a_valid = 1'b1;
        acc_cyc = -100;
        for (int t = 0; t < 100; t++) begin
            @(negedge ref_clk);
            if (a_ready) begin
                @(posedge ref_clk);
                #1;
                a_valid = 1'b0;
                acc_cyc = cyc;
                return;
            end
        end
        check("a_accept_timeout", W'(a_ready), W'(1));
        a_valid = 1'b0;
    endtask

    task automatic push_b(input logic [W-1:0] d);
        b_data  = d;
        b_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge ref_clk);
            if (b_ready) begin
                @(posedge ref_clk);
                #1;
                b_valid = 1'b0;
                return;
            end
        end
        check("b_accept_timeout", W'(b_ready), W'(1));
        b_valid = 1'b0;
    endtask

    task automatic push_c(input logic [W-1:0] d);
        c_data  = d;
        c_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge ref_clk);
            if (c_ready) begin
                @(posedge ref_clk);
                #1;
                c_valid = 1'b0;
                return;
            end
        end
        check("c_accept_timeout", W'(c_ready), W'(1));
        c_valid = 1'b0;
    endtask

    // order 0: B then C; 1: C then B (a_ready must stay low meanwhile); 2: same edge.
    task automatic send_bc(input logic [W-1:0] b, input logic [W-1:0] c, input int order);
        if (order == 0) begin
            push_b(b);
            push_c(c);
        end else if (order == 1) begin
            push_c(c);
            for (int k = 0; k < 3; k++) begin
                @(negedge ref_clk);
                check("a_ready_before_bc", W'(a_ready), W'(0));
                check("c_ready_after_c", W'(c_ready), W'(0));
            end
            @(posedge ref_clk);
            #1;
            push_b(b);
        end else begin
            b_data  = b;
            c_data  = c;
            b_valid = 1'b1;
            c_valid = 1'b1;
            for (int t = 0; t < 100; t++) begin
                @(negedge ref_clk);
                if (b_ready && c_ready) break;
                if (t == 99) check("bc_same_edge_timeout", W'({b_ready, c_ready}), W'(3));
            end
            @(posedge ref_clk);
            #1;
            b_valid = 1'b0;
            c_valid = 1'b0;
        end
    endtask

    task automatic send_rows(input logic [W-1:0] rows[N], input bit gaps, output int last);
        for (int i = 0; i < N; i++) begin
            push_a(rows[i], last);
            if (gaps && i < N - 1) begin
                repeat (1 + (i % 3)) @(posedge ref_clk);
                #1;
            end
        end
    endtask

    task automatic wait_out(output int seen);
        seen = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge ref_clk);
            if (out_valid) begin
                seen = cyc;
                return;
            end
        end
        check("out_valid_timeout", W'(out_valid), W'(1));
    endtask

    task automatic check_lanes(input string name, input int unsigned e0, e1, e2, e3);
        check(name, out_data, pack(e0, e1, e2, e3));
    endtask

    task automatic check_idle_reset();
        check("rst_ready", W'({a_ready, b_ready, c_ready, out_valid}), W'(0));
        check("rst_out_data", out_data, W'(0));
    endtask

    logic [W-1:0] ident[N], ones[N], mix[N];
    logic [W-1:0] b1, c1, all1;
    int last, seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ident[i] = '0;
            ident[i][i*DW +: DW] = 32'd1;
        end
        all1 = '1;
        for (int i = 0; i < N; i++) ones[i] = all1;
        mix[0] = pack(1, 1, 1, 1);
        mix[1] = pack(2, 0, 0, 0);
        mix[2] = pack(0, 0, 0, 5);
        mix[3] = pack(1, 2, 3, 4);
        b1 = pack(1, 2, 3, 4);
        c1 = pack(10, 20, 30, 40);

        rst_n = 1'b1; alpha = '0; beta = '0; out_ready = 1'b1;
        a_data = '0; b_data = '0; c_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_reset();
        repeat (2) @(negedge ref_clk);
        rst_n = 1'b1;
        @(negedge ref_clk);
        check("post_rst_bc_ready", W'({b_ready, c_ready}), W'(3));
        check("post_rst_a_ready", W'(a_ready), W'(0));
        @(posedge ref_clk); #1;

        // 1: identity A, back-to-back rows
        alpha = 2'd3; beta = 2'd2;
        exp_q.push_back(model(ident, b1, c1, 3, 2));
        send_bc(b1, c1, 0);
        send_rows(ident, 1'b0, last);
        @(negedge ref_clk);
        check("a_ready_drop_after_last", W'(a_ready), W'(0));
        wait_out(seen);
        check("t1_latency", W'(seen - last), W'(2));
        check_lanes("t1_lanes", 23, 46, 69, 92);
        @(posedge ref_clk); #1;

        // 2: C before B with gapped rows, then B and C on the same edge
        exp_q.push_back(model(ident, b1, c1, 3, 2));
        send_bc(b1, c1, 1);
        send_rows(ident, 1'b1, last);
        wait_out(seen);
        check_lanes("t2a_lanes", 23, 46, 69, 92);
        @(posedge ref_clk); #1;
        exp_q.push_back(model(ident, b1, c1, 3, 2));
        send_bc(b1, c1, 2);
        send_rows(ident, 1'b1, last);
        wait_out(seen);
        check("t2b_latency", W'(seen - last), W'(2));
        check_lanes("t2b_lanes", 23, 46, 69, 92);
        @(posedge ref_clk); #1;

        // 3: overflow
        alpha = 2'd3; beta = 2'd2;
        exp_q.push_back(model(ones, all1, '0, 3, 2));
        send_bc(all1, '0, 0);
        send_rows(ones, 1'b0, last);
        wait_out(seen);
`ifdef GEMV_SAT_EN
        check_lanes("t3_lanes", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        check_lanes("t3_lanes", 32'hC, 32'hC, 32'hC, 32'hC);
`endif
        @(posedge ref_clk); #1;

        // 4: output back-pressure
        alpha = 2'd1; beta = 2'd3;
        out_ready = 1'b0;
        exp_q.push_back(model(mix, pack(5, 6, 7, 8), pack(1, 1, 1, 1), 1, 3));
        send_bc(pack(5, 6, 7, 8), pack(1, 1, 1, 1), 0);
        send_rows(mix, 1'b0, last);
        wait_out(seen);
        for (int k = 0; k < 5; k++) begin
            @(negedge ref_clk);
            check("t4_hold_valid", W'(out_valid), W'(1));
        end
        @(posedge ref_clk); #1;
        out_ready = 1'b1;
        @(negedge ref_clk);
        check("t4_valid_7th", W'(out_valid), W'(1));
        @(negedge ref_clk);
        check("t4_valid_after_hs", W'(out_valid), W'(0));
        check("t4_bc_ready_after_hs", W'({b_ready, c_ready}), W'(3));
        @(posedge ref_clk); #1;

        // 5: reset after two rows, then a clean job
        send_bc(b1, c1, 0);
        push_a(ident[0], last);
        push_a(ident[1], last);
        rst_n = 1'b0;
        #1 check_idle_reset();
        repeat (2) @(negedge ref_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ref_clk);
            check("t5_no_stale_out", W'(out_valid), W'(0));
        end
        @(posedge ref_clk); #1;
        alpha = 2'd3; beta = 2'd2;
        exp_q.push_back(model(ident, b1, c1, 3, 2));
        send_bc(b1, c1, 0);
        send_rows(ident, 1'b0, last);
        wait_out(seen);
        check_lanes("t5_lanes", 23, 46, 69, 92);
        @(posedge ref_clk); #1;

        // 6: alpha/beta change mid-job; extra a_valid after N rows ignored
        alpha = 2'd3; beta = 2'd1;
        exp_q.push_back(model(mix, b1, pack(5, 6, 7, 8), 3, 1));
        send_bc(b1, pack(5, 6, 7, 8), 0);
        push_a(mix[0], last);
        alpha = 2'd1; beta = 2'd0;
        for (int i = 1; i < N; i++) push_a(mix[i], last);
        a_data  = all1;
        a_valid = 1'b1;
        wait_out(seen);
        check("t6_a_ready_after_n", W'(a_ready), W'(0));
        check_lanes("t6_lanes", 35, 12, 67, 98);
        @(posedge ref_clk); #1;
        a_valid = 1'b0;

        repeat (3) @(negedge ref_clk);
        check("all_outputs_seen", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
